seconds_countdown: RTL and testbench

SECONDS_COUNTDOWN -- requirements
Module: seconds_countdown

---
 rtl/seconds_countdown.sv | 136 +++++++++++++
 tb/tb_seconds_countdown.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seconds_countdown.sv
// Seconds stage of a kitchen-timer countdown: BCD ss digits, 1 s prescaler,
// borrow pulse to the minutes stage and a done flag at 00:00.
module seconds_countdown #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       loadn,
  input  logic [3:0] data_ones,
  input  logic [3:0] data_tens,
  input  logic       start,
  input  logic       stop,
  input  logic       min_zero,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry_out,
  output logic       min_en,
  output logic       running,
  output logic       done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic          carry_q, carry_d;
  logic          min_en_q, min_en_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic [PW-1:0] presc_q, presc_d;

  logic [3:0] dt_clamp, do_clamp, ld_tens;
  logic       ld_carry;
  logic       can_run;

  // Keypad tens of 6..9 are folded into a +1 minute carry.
  always_comb begin
    dt_clamp = (data_tens > 4'd9) ? 4'd9 : data_tens;
    do_clamp = (data_ones > 4'd9) ? 4'd9 : data_ones;
    ld_tens  = dt_clamp;
    ld_carry = 1'b0;
    if (dt_clamp >= 4'd6) begin
      ld_tens  = dt_clamp - 4'd6;
      ld_carry = 1'b1;
    end
  end

  assign can_run = start && !stop && ((tens_q != 4'd0) || (ones_q != 4'd0) || !min_zero);

  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    tens_d   = tens_q;
    carry_d  = carry_q;
    presc_d  = presc_q;
    min_en_d = 1'b0;
    case (state_q)
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (presc_q == TERM) begin
          presc_d = '0;
          if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else if (tens_q != 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else if (!min_zero) begin
            tens_d   = 4'd5;
            ones_d   = 4'd9;
            min_en_d = 1'b1;
          end
          if ((ones_d == 4'd0) && (tens_d == 4'd0) && min_zero) begin
            state_d = DONE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        if (!loadn) begin
          tens_d  = ld_tens;
          ones_d  = do_clamp;
          carry_d = ld_carry;
          state_d = IDLE;
        end else if ((state_q != DONE) && can_run) begin
          state_d = RUN;
          if (state_q == IDLE) begin
            presc_d = '0;
          end
        end
      end
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      ones_q    <= '0;
      tens_q    <= '0;
      carry_q   <= 1'b0;
      min_en_q  <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      presc_q   <= '0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      carry_q   <= carry_d;
      min_en_q  <= min_en_d;
      running_q <= running_d;
      done_q    <= done_d;
      presc_q   <= presc_d;
    end
  end

  assign ones      = ones_q;
  assign tens      = tens_q;
  assign carry_out = carry_q;
  assign min_en    = min_en_q;
  assign running   = running_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seconds_countdown.sv
// Scoreboard bench for seconds_countdown at TICK_DIV=4: stimulus queues the
// expected outputs, a monitor pops and compares them after each check point.
module tb_seconds_countdown;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       loadn = 1'b1;
  logic [3:0] data_ones = '0;
  logic [3:0] data_tens = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       min_zero = 1'b1;
  logic [3:0] ones, tens;
  logic       carry_out, min_en, running, done;

  seconds_countdown #(.TICK_DIV(4)) dut (
    .clk(clk), .clear(clear), .loadn(loadn),
    .data_ones(data_ones), .data_tens(data_tens),
    .start(start), .stop(stop), .min_zero(min_zero),
    .ones(ones), .tens(tens), .carry_out(carry_out),
    .min_en(min_en), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [11:0] v;   // {tens, ones, carry_out, min_en, running, done}
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  logic kick = 1'b0;

  // Monitor: after every rising edge (or an out-of-band kick) compare one entry.
  initial begin
    forever begin
      @(posedge clk or kick);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        logic [11:0] got;
        e   = q.pop_front();
        got = {tens, ones, carry_out, min_en, running, done};
        total++;
        if (got !== e.v) begin
          bad++;
          $display("FAIL %s got=%h exp=%h (tens,ones,carry,min_en,running,done)", e.nm, got, e.v);
        end
      end
    end
  end

  task automatic push(input string nm, input logic [3:0] t, input logic [3:0] o,
                      input logic c, input logic me, input logic r, input logic d);
    exp_t e;
    e.nm = nm;
    e.v  = {t, o, c, me, r, d};
    q.push_back(e);
  endtask

  // Queue expectation for the coming rising edge, then move to the next falling edge.
  task automatic cyc(input string nm, input logic [3:0] t, input logic [3:0] o,
                     input logic c, input logic me, input logic r, input logic d);
    push(nm, t, o, c, me, r, d);
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] dt, input logic [3:0] d1);
    loadn = 1'b0; data_tens = dt; data_ones = d1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    cyc("reset_held", 0, 0, 0, 0, 0, 0);
    clear = 1'b0;
    cyc("reset_state", 0, 0, 0, 0, 0, 0);

    // Load with carry, clamping and carry clear
    load(7, 5);   cyc("load75", 1, 5, 1, 0, 0, 0);
    loadn = 1'b1; cyc("load75_hold", 1, 5, 1, 0, 0, 0);
    load(12, 11); cyc("load_clamp", 3, 9, 1, 0, 0, 0);
    load(3, 0);   cyc("load30", 3, 0, 0, 0, 0, 0);

    // Count 05 down to done with min_zero=1
    load(0, 5);   cyc("load05", 0, 5, 0, 0, 0, 0);
    loadn = 1'b1; start = 1'b1;
    cyc("run05", 0, 5, 0, 0, 1, 0);
    start = 1'b0;
    for (int v = 4; v >= 1; v--) begin
      repeat (3) cyc("hold_step", 0, 4'(v + 1), 0, 0, 1, 0);
      cyc("step", 0, 4'(v), 0, 0, 1, 0);
    end
    repeat (3) cyc("hold01", 0, 1, 0, 0, 1, 0);
    cyc("reach_done", 0, 0, 0, 0, 0, 1);
    start = 1'b1;
    repeat (3) cyc("done_ignores_start", 0, 0, 0, 0, 0, 1);
    start = 1'b0;

    // 00 with minutes left: borrow to 59 and one-cycle min_en
    min_zero = 1'b0;
    load(0, 0);   cyc("load_exit_done", 0, 0, 0, 0, 0, 0);
    loadn = 1'b1; start = 1'b1;
    cyc("run00", 0, 0, 0, 0, 1, 0);
    start = 1'b0;
    repeat (3) cyc("hold00", 0, 0, 0, 0, 1, 0);
    cyc("borrow59", 5, 9, 0, 1, 1, 0);
    cyc("min_en_drop", 5, 9, 0, 0, 1, 0);
    stop = 1'b1;
    cyc("pause59", 5, 9, 0, 0, 0, 0);
    stop = 1'b0;

    // Pause mid-prescaler, resume with remaining count
    min_zero = 1'b1;
    load(3, 1);   cyc("load31", 3, 1, 0, 0, 0, 0);
    loadn = 1'b1; start = 1'b1;
    cyc("run31", 3, 1, 0, 0, 1, 0);
    start = 1'b0;
    repeat (3) cyc("hold31", 3, 1, 0, 0, 1, 0);
    cyc("step30", 3, 0, 0, 0, 1, 0);
    repeat (2) cyc("pre_stop30", 3, 0, 0, 0, 1, 0);
    stop = 1'b1;
    cyc("pause30", 3, 0, 0, 0, 0, 0);
    stop = 1'b0;
    repeat (100) cyc("paused30", 3, 0, 0, 0, 0, 0);
    start = 1'b1;
    cyc("resume30", 3, 0, 0, 0, 1, 0);
    start = 1'b0;
    cyc("resume_hold30", 3, 0, 0, 0, 1, 0);
    cyc("resume_step29", 2, 9, 0, 0, 1, 0);

    // start and stop together: stop wins in RUN, no entry from PAUSE
    start = 1'b1; stop = 1'b1;
    cyc("both_in_run", 2, 9, 0, 0, 0, 0);
    repeat (2) cyc("both_in_pause", 2, 9, 0, 0, 0, 0);
    start = 1'b0; stop = 1'b0;

    // Asynchronous clear just before a borrow step
    min_zero = 1'b0;
    load(6, 2);   cyc("load62", 0, 2, 1, 0, 0, 0);
    loadn = 1'b1; start = 1'b1;
    cyc("run02", 0, 2, 1, 0, 1, 0);
    start = 1'b0;
    repeat (3) cyc("hold02", 0, 2, 1, 0, 1, 0);
    cyc("step01", 0, 1, 1, 0, 1, 0);
    repeat (3) cyc("hold01b", 0, 1, 1, 0, 1, 0);
    cyc("step00", 0, 0, 1, 0, 1, 0);
    repeat (3) cyc("hold00b", 0, 0, 1, 0, 1, 0);
    #2 clear = 1'b1;
    push("clear_async", 0, 0, 0, 0, 0, 0);
    kick = ~kick;
    #2 clear = 1'b0;
    repeat (3) cyc("no_borrow_after_clear", 0, 0, 0, 0, 0, 0);

    // Start refused at 00 with min_zero=1; start+stop refused in IDLE
    min_zero = 1'b1; start = 1'b1;
    repeat (2) cyc("idle_00_no_run", 0, 0, 0, 0, 0, 0);
    start = 1'b0;
    load(1, 2);   cyc("load12", 1, 2, 0, 0, 0, 0);
    loadn = 1'b1; start = 1'b1; stop = 1'b1;
    repeat (2) cyc("idle_both_no_run", 1, 2, 0, 0, 0, 0);
    start = 1'b0; stop = 1'b0;

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
